// File: rtl/mem_arbiter.sv
// Arbiter and access sequencer that shares one single-ported memory between the fetch and data ports.
// Optional feature: define MEM_ARB_PERF_EN to add saturating per-port stall-cycle counters.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        owner_dm;
  logic        lat_we;

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;

  // Memory-side outputs are registered at grant time so they appear exactly in the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          // Data port wins: it holds the older instruction in the pipeline.
          if (dm_req && !dm_ready) begin
            owner_dm  <= 1'b1;
            lat_we    <= dm_we;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= ISSUE;
          end else if (if_req && !if_ready) begin
            owner_dm  <= 1'b0;
            lat_we    <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= if_addr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            dm_ready <= owner_dm;
            if_ready <= ~owner_dm;
            state    <= DONE;
          end else begin
            cnt   <= 3'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            if (owner_dm) begin
              dm_rdata <= mem_rdata;
              dm_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            state <= DONE;
          end
          cnt <= cnt - 3'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_stall <= 32'd0;
      perf_dm_stall <= 32'd0;
    end else begin
      if (stall_if && perf_if_stall != 32'hFFFF_FFFF) perf_if_stall <= perf_if_stall + 32'd1;
      if (stall_dm && perf_dm_stall != 32'hFFFF_FFFF) perf_dm_stall <= perf_dm_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and access sequencer sharing one single-ported unified memory between the pipeline's fetch stage (instruction port) and memory stage (data port). It serialises requests, drives the memory one transaction at a time, returns read data with a one-cycle ready pulse, and produces per-port stall signals that freeze the corresponding pipeline stages. It sits between the pipelined `mips` core and the external memory model, replacing separate instruction/data memories.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MEM_LAT`, 2, memory read latency in cycles, legal range 1..7

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch stage requests an instruction read
- `if_addr`  in  ADDR_W  fetch address (the `pc`)
- `if_rdata`  out  DATA_W  instruction, valid when `if_ready`
- `if_ready`  out  1  one-cycle pulse: fetch transaction complete
- `stall_if`  out  1  `if_req & ~if_ready`
- `dm_req`  in  1  memory stage requests access
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data address (`aluresult`)
- `dm_wdata`  in  DATA_W  store data (`writedata`)
- `dm_rdata`  out  DATA_W  load data, valid when `dm_ready`
- `dm_ready`  out  1  one-cycle pulse: data transaction complete
- `stall_dm`  out  1  `dm_req & ~dm_ready`
- `mem_en`  out  1  memory access strobe, one cycle per transaction
- `mem_we`  out  1  memory write enable, only with `mem_en`
- `mem_addr`  out  ADDR_W  registered access address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. 3-bit latency counter.
- IDLE: sample requests. Data port has fixed priority over fetch (older instruction). A port whose ready is high this cycle is ignored (prevents duplicate access while requester advances). On grant: latch owner, address, `we`, wdata; go ISSUE.
- ISSUE (one cycle): `mem_en`=1, `mem_we`=latched `we`, `mem_addr`/`mem_wdata` from latches. Write: go DONE. Read: load counter with `MEM_LAT`, go WAIT.
- WAIT: decrement counter; when counter reaches 1, capture `mem_rdata` into owner's rdata register, go DONE.
- DONE: owner's ready pulses one cycle; state returns to IDLE at the next edge. In DONE/IDLE transitions requests are re-sampled only from IDLE.
- Writes leave `dm_rdata` unchanged. `if_rdata`/`dm_rdata` hold last captured value until next capture.
- Request inputs are sampled only in IDLE; changes during ISSUE/WAIT are ignored.
- `mem_addr`, `mem_wdata`, `mem_we` are 0 whenever `mem_en`=0.

## Timing
- Request high in cycle C (state IDLE) → `mem_en` in C+1.
- Read: `mem_rdata` valid in cycle C+1+MEM_LAT, ready pulse in C+2+MEM_LAT.
- Write: ready pulse in C+2.
- Both requests in C: data served first; fetch `mem_en` at data-ready cycle +2 (IDLE re-sample).
- Reset values: state IDLE, all ready 0, `mem_en`/`mem_we` 0, `mem_addr`/`mem_wdata`/`if_rdata`/`dm_rdata` 0, counter 0.
- Reset mid-transaction: aborted at next edge, no ready pulse, `mem_en` low the cycle after reset.
- `stall_if`/`stall_dm` combinational from req and ready.

## Configuration
- `MEM_ARB_PERF_EN` defined: adds outputs `perf_if_stall` and `perf_dm_stall` (32-bit each), incremented every cycle the respective stall is high, saturating at 0xFFFF_FFFF, cleared by reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- MEM_LAT=2, `if_req` at cycle 0, `if_addr`=0x10, memory returns 0x2002_0005 → `mem_en` cycle 1 with `mem_addr`=0x10, `if_ready` and `if_rdata`=0x2002_0005 in cycle 4, `stall_if` high cycles 0–3.
- `dm_req` write, `dm_addr`=0x54, `dm_wdata`=0xDEAD_BEEF at cycle 0 → cycle 1 `mem_en`=`mem_we`=1 with those values, `dm_ready` cycle 2, `dm_rdata` unchanged.
- `if_req` and `dm_req` read together at cycle 0, MEM_LAT=2 → data `mem_en` cycle 1, `dm_ready` cycle 4, fetch `mem_en` cycle 6, `if_ready` cycle 9.
- `if_req` held high 20 cycles, MEM_LAT=1 → exactly one `mem_en` per `if_ready`, period 4 cycles, no duplicate access in ready cycle.
- Reset asserted during WAIT → no ready pulse, all outputs 0 next cycle, new `if_req` after reset served normally.
- With `MEM_ARB_PERF_EN`: scenario 1 → `perf_if_stall`=4, `perf_dm_stall`=0; reset clears both.
